// File: rtl/core2axi_pkg.sv
// Shared types and helpers for the pipelined core-to-AXI bridge.
package core2axi_pkg;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_EXOKAY = 2'b01,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } resp_t;

    typedef enum logic {
        TXN_READ  = 1'b0,
        TXN_WRITE = 1'b1
    } txn_type_t;

    typedef enum logic [1:0] {
        WR_IDLE    = 2'b00,
        WR_AW_DONE = 2'b01,
        WR_W_DONE  = 2'b10
    } wr_state_t;

    localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;

    // 32-bit lane index of a byte address within one AXI data beat
    function automatic logic [1:0] lane_offset(input logic [31:0] addr,
                                               input int unsigned data_width);
        logic [31:0] lane_mask;
        lane_mask = 32'(data_width / 8) - 32'd1;
        return 2'((addr & lane_mask) >> 2);
    endfunction

endpackage

// File: rtl/core2axi_pipe_if.sv
// AXI4 master/slave channel bundle used by the core-to-AXI bridge.
interface core2axi_pipe_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned ID_WIDTH   = 16,
    parameter int unsigned USER_WIDTH = 10
);
    logic [ID_WIDTH-1:0]     aw_id;
    logic [ADDR_WIDTH-1:0]   aw_addr;
    logic [7:0]              aw_len;
    logic [2:0]              aw_size;
    logic [1:0]              aw_burst;
    logic                    aw_lock;
    logic [3:0]              aw_cache;
    logic [2:0]              aw_prot;
    logic [3:0]              aw_region;
    logic [USER_WIDTH-1:0]   aw_user;
    logic [3:0]              aw_qos;
    logic                    aw_valid;
    logic                    aw_ready;

    logic [DATA_WIDTH-1:0]   w_data;
    logic [DATA_WIDTH/8-1:0] w_strb;
    logic                    w_last;
    logic [USER_WIDTH-1:0]   w_user;
    logic                    w_valid;
    logic                    w_ready;

    logic [ID_WIDTH-1:0]     b_id;
    logic [1:0]              b_resp;
    logic [USER_WIDTH-1:0]   b_user;
    logic                    b_valid;
    logic                    b_ready;

    logic [ID_WIDTH-1:0]     ar_id;
    logic [ADDR_WIDTH-1:0]   ar_addr;
    logic [7:0]              ar_len;
    logic [2:0]              ar_size;
    logic [1:0]              ar_burst;
    logic                    ar_lock;
    logic [3:0]              ar_cache;
    logic [2:0]              ar_prot;
    logic [3:0]              ar_region;
    logic [USER_WIDTH-1:0]   ar_user;
    logic [3:0]              ar_qos;
    logic                    ar_valid;
    logic                    ar_ready;

    logic [ID_WIDTH-1:0]     r_id;
    logic [DATA_WIDTH-1:0]   r_data;
    logic [1:0]              r_resp;
    logic                    r_last;
    logic [USER_WIDTH-1:0]   r_user;
    logic                    r_valid;
    logic                    r_ready;

    modport master (
        output aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache,
               aw_prot, aw_region, aw_user, aw_qos, aw_valid,
        input  aw_ready,
        output w_data, w_strb, w_last, w_user, w_valid,
        input  w_ready,
        input  b_id, b_resp, b_user, b_valid,
        output b_ready,
        output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache,
               ar_prot, ar_region, ar_user, ar_qos, ar_valid,
        input  ar_ready,
        input  r_id, r_data, r_resp, r_last, r_user, r_valid,
        output r_ready
    );

    modport slave (
        input  aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache,
               aw_prot, aw_region, aw_user, aw_qos, aw_valid,
        output aw_ready,
        input  w_data, w_strb, w_last, w_user, w_valid,
        output w_ready,
        output b_id, b_resp, b_user, b_valid,
        input  b_ready,
        input  ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache,
               ar_prot, ar_region, ar_user, ar_qos, ar_valid,
        output ar_ready,
        output r_id, r_data, r_resp, r_last, r_user, r_valid,
        input  r_ready
    );

endinterface

// File: rtl/core2axi_txn_fifo.sv
// In-order FIFO of per-transaction lane offsets; push and pop may coincide even when full.
module core2axi_txn_fifo #(
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned DATA_WIDTH = 1
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         push_i,
    input  logic [DATA_WIDTH-1:0]        push_data_i,
    input  logic                         pop_i,
    output logic [DATA_WIDTH-1:0]        head_o,
    output logic                         full_o,
    output logic                         empty_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      count;
    logic                  do_push;
    logic                  do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
    endfunction

    assign full_o  = (count == CNT_W'(DEPTH));
    assign empty_o = (count == '0);
    assign count_o = count;
    assign head_o  = mem[rd_ptr];

    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= ptr_inc(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem[wr_ptr] <= push_data_i;
    end

endmodule

// File: rtl/core2axi_pipe.sv
// Core req/gnt/rvalid port to AXI4 single-beat bridge with up to MAX_OUTSTANDING in-order transactions.
module core2axi_pipe
    import core2axi_pkg::*;
#(
    parameter int unsigned AXI4_ADDRESS_WIDTH = 32,
    parameter int unsigned AXI4_DATA_WIDTH    = 64,
    parameter int unsigned AXI4_ID_WIDTH      = 16,
    parameter int unsigned AXI4_USER_WIDTH    = 10,
    parameter int unsigned MAX_OUTSTANDING    = 4,
    parameter int unsigned AXI_ID_VALUE       = 0
) (
    input  logic                          clk_i,
    input  logic                          rst_i,

    input  logic                          data_req_i,
    output logic                          data_gnt_o,
    output logic                          data_rvalid_o,
    output logic                          data_err_o,
    input  logic [AXI4_ADDRESS_WIDTH-1:0] data_addr_i,
    input  logic                          data_we_i,
    input  logic [3:0]                    data_be_i,
    input  logic [31:0]                   data_wdata_i,
    output logic [31:0]                   data_rdata_o,

    core2axi_pipe_if.master               axi
);
    localparam int unsigned NUM_LANES = AXI4_DATA_WIDTH / 32;
    localparam int unsigned LANE_BITS = $clog2(NUM_LANES);
    localparam int unsigned OFF_W     = (LANE_BITS > 0) ? LANE_BITS : 1;
    localparam int unsigned CNT_W     = $clog2(MAX_OUTSTANDING + 1);

    if (!(AXI4_DATA_WIDTH == 32 || AXI4_DATA_WIDTH == 64 || AXI4_DATA_WIDTH == 128)) begin : g_bad_data_width
        $error("core2axi_pipe: AXI4_DATA_WIDTH must be 32, 64 or 128");
    end
    if (MAX_OUTSTANDING < 1 || MAX_OUTSTANDING > 16) begin : g_bad_outstanding
        $error("core2axi_pipe: MAX_OUTSTANDING must be in 1..16");
    end

    txn_type_t                   outstanding_we;
    wr_state_t                   wr_state;
    wr_state_t                   wr_state_next;
    logic                        aw_done;
    logic                        w_done;
    logic                        issue_ok;
    logic                        same_type;
    logic                        aw_hs;
    logic                        w_hs;
    logic                        rd_grant;
    logic                        wr_grant;
    logic                        grant;
    logic                        r_ready;
    logic                        b_ready;
    logic                        r_fire;
    logic                        b_fire;
    logic                        rsp;
    logic [1:0]                  addr_lane;
    logic [OFF_W-1:0]            push_off;
    logic [OFF_W-1:0]            head_off;
    logic                        fifo_full;
    logic                        fifo_empty;
    logic [CNT_W-1:0]            count;
    logic [NUM_LANES-1:0][3:0]   strb_lanes;
    logic [NUM_LANES-1:0][31:0]  r_lanes;

    // Mixing reads and writes would let B and R responses overtake each other, so a type switch waits for the pipe to drain
    assign same_type = ((outstanding_we == TXN_WRITE) == data_we_i);
    assign issue_ok  = data_req_i && !fifo_full && (fifo_empty || same_type);

    assign axi.ar_valid = issue_ok && !data_we_i;
    assign axi.aw_valid = issue_ok && data_we_i && !aw_done;
    assign axi.w_valid  = issue_ok && data_we_i && !w_done;

    assign rd_grant = axi.ar_valid && axi.ar_ready;
    assign aw_hs    = axi.aw_valid && axi.aw_ready;
    assign w_hs     = axi.w_valid && axi.w_ready;
    assign wr_grant = issue_ok && data_we_i && (aw_done || aw_hs) && (w_done || w_hs);
    assign grant    = rd_grant || wr_grant;

    assign data_gnt_o = grant;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) wr_state <= WR_IDLE;
        else       wr_state <= wr_state_next;
    end

    always_comb begin
        wr_state_next = wr_state;
        unique case (wr_state)
            WR_IDLE: begin
                if (!wr_grant) begin
                    if (aw_hs)     wr_state_next = WR_AW_DONE;
                    else if (w_hs) wr_state_next = WR_W_DONE;
                end
            end
            WR_AW_DONE, WR_W_DONE: begin
                if (wr_grant) wr_state_next = WR_IDLE;
            end
            default: wr_state_next = WR_IDLE;
        endcase
    end

    always_comb begin
        aw_done = (wr_state == WR_AW_DONE);
        w_done  = (wr_state == WR_W_DONE);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)      outstanding_we <= TXN_READ;
        else if (grant) outstanding_we <= data_we_i ? TXN_WRITE : TXN_READ;
    end

    assign addr_lane = lane_offset(32'(data_addr_i), AXI4_DATA_WIDTH);
    assign push_off  = addr_lane[OFF_W-1:0];

    core2axi_txn_fifo #(
        .DEPTH      (MAX_OUTSTANDING),
        .DATA_WIDTH (OFF_W)
    ) u_txn_fifo (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .push_i      (grant),
        .push_data_i (push_off),
        .pop_i       (rsp),
        .head_o      (head_off),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .count_o     (count)
    );

    assign r_ready     = !fifo_empty && (outstanding_we == TXN_READ);
    assign b_ready     = !fifo_empty && (outstanding_we == TXN_WRITE);
    assign axi.r_ready = r_ready;
    assign axi.b_ready = b_ready;

    assign r_fire = axi.r_valid && r_ready;
    assign b_fire = axi.b_valid && b_ready;
    assign rsp    = r_fire || b_fire;

    assign data_rvalid_o = rsp;
    assign data_err_o    = r_fire ? axi.r_resp[1] : (b_fire ? axi.b_resp[1] : 1'b0);

    assign r_lanes      = axi.r_data;
    assign data_rdata_o = r_fire ? r_lanes[head_off] : '0;

    always_comb begin
        strb_lanes           = '0;
        strb_lanes[push_off] = data_be_i;
    end

    assign axi.w_data = {NUM_LANES{data_wdata_i}};
    assign axi.w_strb = strb_lanes;
    assign axi.w_last = 1'b1;
    assign axi.w_user = '0;

    assign axi.aw_id     = AXI4_ID_WIDTH'(AXI_ID_VALUE);
    assign axi.aw_addr   = data_addr_i;
    assign axi.aw_len    = 8'd0;
    assign axi.aw_size   = AXI_SIZE_4B;
    assign axi.aw_burst  = AXI_BURST_INCR;
    assign axi.aw_lock   = 1'b0;
    assign axi.aw_cache  = 4'd0;
    assign axi.aw_prot   = 3'd0;
    assign axi.aw_region = 4'd0;
    assign axi.aw_user   = '0;
    assign axi.aw_qos    = 4'd0;

    assign axi.ar_id     = AXI4_ID_WIDTH'(AXI_ID_VALUE);
    assign axi.ar_addr   = data_addr_i;
    assign axi.ar_len    = 8'd0;
    assign axi.ar_size   = AXI_SIZE_4B;
    assign axi.ar_burst  = AXI_BURST_INCR;
    assign axi.ar_lock   = 1'b0;
    assign axi.ar_cache  = 4'd0;
    assign axi.ar_prot   = 3'd0;
    assign axi.ar_region = 4'd0;
    assign axi.ar_user   = '0;
    assign axi.ar_qos    = 4'd0;

    logic unused_sigs;
    assign unused_sigs = ^{axi.b_id, axi.b_resp[0], axi.b_user, axi.r_id, axi.r_resp[0],
                           axi.r_last, axi.r_user, addr_lane, count};

endmodule

// File: tb/tb_core2axi_pipe.sv
// Directed bench for core2axi_pipe with 64-bit AXI data and four outstanding transactions.
module tb_core2axi_pipe;
    import core2axi_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        data_req;
    logic        data_gnt;
    logic        data_rvalid;
    logic        data_err;
    logic [31:0] data_addr;
    logic        data_we;
    logic [3:0]  data_be;
    logic [31:0] data_wdata;
    logic [31:0] data_rdata;
    logic [31:0] exp;

    int unsigned n_chk = 0;
    int unsigned n_fail = 0;

    core2axi_pipe_if #(.ADDR_WIDTH(32), .DATA_WIDTH(64), .ID_WIDTH(16), .USER_WIDTH(10)) axi ();

    core2axi_pipe #(
        .AXI4_ADDRESS_WIDTH (32),
        .AXI4_DATA_WIDTH    (64),
        .AXI4_ID_WIDTH      (16),
        .AXI4_USER_WIDTH    (10),
        .MAX_OUTSTANDING    (4),
        .AXI_ID_VALUE       (0)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .data_req_i    (data_req),
        .data_gnt_o    (data_gnt),
        .data_rvalid_o (data_rvalid),
        .data_err_o    (data_err),
        .data_addr_i   (data_addr),
        .data_we_i     (data_we),
        .data_be_i     (data_be),
        .data_wdata_i  (data_wdata),
        .data_rdata_o  (data_rdata),
        .axi           (axi)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_chk++; if (data_gnt !== 1'b0) begin n_fail++; $display("FAIL rst_gnt: got %0b want 0", data_gnt); end
        n_chk++; if (data_rvalid !== 1'b0) begin n_fail++; $display("FAIL rst_rvalid: got %0b want 0", data_rvalid); end
        n_chk++; if (data_err !== 1'b0) begin n_fail++; $display("FAIL rst_err: got %0b want 0", data_err); end
        n_chk++; if ({axi.ar_valid, axi.aw_valid, axi.w_valid} !== 3'b000) begin n_fail++; $display("FAIL rst_valids: got %b want 000", {axi.ar_valid, axi.aw_valid, axi.w_valid}); end
        n_chk++; if ({axi.r_ready, axi.b_ready} !== 2'b00) begin n_fail++; $display("FAIL rst_readies: got %b want 00", {axi.r_ready, axi.b_ready}); end
        n_chk++; if (axi.ar_size !== 3'b010) begin n_fail++; $display("FAIL const_size: got %b want 010", axi.ar_size); end
        n_chk++; if ({axi.w_last, axi.aw_len, axi.aw_burst} !== {1'b1, 8'd0, 2'b01}) begin n_fail++; $display("FAIL const_fields: got %h want 101", {axi.w_last, axi.aw_len, axi.aw_burst}); end
        rst = 1'b0;
        cyc();
        axi.r_valid = 1'b1; axi.b_valid = 1'b1; axi.r_data = 64'h1234_5678_9ABC_DEF0; #2;
        n_chk++; if (data_rvalid !== 1'b0) begin n_fail++; $display("FAIL stray_rvalid: got %0b want 0", data_rvalid); end
        n_chk++; if (data_rdata !== 32'h0) begin n_fail++; $display("FAIL stray_rdata: got %h want 0", data_rdata); end
        cyc();
        axi.r_valid = 1'b0; axi.b_valid = 1'b0;
    endtask

    task automatic test_read_single();
        cyc();
        data_req = 1'b1; data_we = 1'b0; data_addr = 32'h104; axi.ar_ready = 1'b1; #2;
        n_chk++; if (axi.ar_valid !== 1'b1) begin n_fail++; $display("FAIL rd_arvalid: got %0b want 1", axi.ar_valid); end
        n_chk++; if (data_gnt !== 1'b1) begin n_fail++; $display("FAIL rd_gnt: got %0b want 1", data_gnt); end
        n_chk++; if (axi.ar_addr !== 32'h104) begin n_fail++; $display("FAIL rd_araddr: got %h want 104", axi.ar_addr); end
        cyc();
        data_req = 1'b0; axi.ar_ready = 1'b0; #2;
        n_chk++; if (axi.r_ready !== 1'b1) begin n_fail++; $display("FAIL rd_rready: got %0b want 1", axi.r_ready); end
        cyc();
        axi.r_valid = 1'b1; axi.r_data = 64'hAAAA_BBBB_1111_2222; axi.r_resp = RESP_OKAY; #2;
        n_chk++; if (data_rvalid !== 1'b1) begin n_fail++; $display("FAIL rd_rvalid: got %0b want 1", data_rvalid); end
        n_chk++; if (data_rdata !== 32'hAAAA_BBBB) begin n_fail++; $display("FAIL rd_rdata: got %h want aaaabbbb", data_rdata); end
        n_chk++; if (data_err !== 1'b0) begin n_fail++; $display("FAIL rd_err: got %0b want 0", data_err); end
        cyc();
        axi.r_valid = 1'b0; #2;
        n_chk++; if (axi.r_ready !== 1'b0) begin n_fail++; $display("FAIL rd_rready_idle: got %0b want 0", axi.r_ready); end
    endtask

    task automatic test_back_to_back();
        axi.ar_ready = 1'b1; data_we = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cyc();
            data_req = 1'b1; data_addr = 32'(i * 4); #2;
            n_chk++; if (data_gnt !== 1'b1) begin n_fail++; $display("FAIL b2b_gnt%0d: got %0b want 1", i, data_gnt); end
        end
        cyc();
        data_addr = 32'h10; axi.ar_ready = 1'b0; #2;
        n_chk++; if (axi.ar_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_full_arvalid: got %0b want 0", axi.ar_valid); end
        n_chk++; if (data_gnt !== 1'b0) begin n_fail++; $display("FAIL b2b_full_gnt: got %0b want 0", data_gnt); end
        cyc();
        axi.r_valid = 1'b1; axi.r_resp = RESP_OKAY; axi.r_data = {32'hB000_0000, 32'hA000_0000}; #2;
        n_chk++; if (data_rdata !== 32'hA000_0000) begin n_fail++; $display("FAIL b2b_rdata0: got %h want a0000000", data_rdata); end
        n_chk++; if (axi.ar_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_pop_arvalid: got %0b want 0", axi.ar_valid); end
        cyc();
        axi.r_valid = 1'b0; axi.ar_ready = 1'b1; #2;
        n_chk++; if (data_gnt !== 1'b1) begin n_fail++; $display("FAIL b2b_refill_gnt: got %0b want 1", data_gnt); end
        cyc();
        data_req = 1'b0; axi.ar_ready = 1'b0;
        for (int i = 1; i < 5; i++) begin
            axi.r_valid = 1'b1;
            axi.r_data = {32'(32'hB000_0000 + i), 32'(32'hA000_0000 + i)};
            exp = (i % 2 == 1) ? 32'(32'hB000_0000 + i) : 32'(32'hA000_0000 + i);
            #2;
            n_chk++; if (data_rvalid !== 1'b1 || data_rdata !== exp) begin n_fail++; $display("FAIL b2b_rsp%0d: got %0b/%h want 1/%h", i, data_rvalid, data_rdata, exp); end
            cyc();
        end
        axi.r_valid = 1'b0; #2;
        n_chk++; if (axi.r_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_drained: got %0b want 0", axi.r_ready); end
    endtask

    task automatic test_write_split();
        cyc();
        data_req = 1'b1; data_we = 1'b1; data_addr = 32'h208; data_be = 4'b0011; data_wdata = 32'hDEAD_BEEF;
        axi.aw_ready = 1'b1; axi.w_ready = 1'b0; #2;
        n_chk++; if ({axi.aw_valid, axi.w_valid, data_gnt} !== 3'b110) begin n_fail++; $display("FAIL wr_c0_valids: got %b want 110", {axi.aw_valid, axi.w_valid, data_gnt}); end
        n_chk++; if (axi.w_strb !== 8'h03) begin n_fail++; $display("FAIL wr_strb: got %h want 03", axi.w_strb); end
        n_chk++; if (axi.w_data !== 64'hDEAD_BEEF_DEAD_BEEF) begin n_fail++; $display("FAIL wr_wdata: got %h want deadbeefdeadbeef", axi.w_data); end
        cyc();
        axi.aw_ready = 1'b0; #2;
        n_chk++; if ({axi.aw_valid, axi.w_valid, data_gnt} !== 3'b010) begin n_fail++; $display("FAIL wr_c1_valids: got %b want 010", {axi.aw_valid, axi.w_valid, data_gnt}); end
        cyc(); cyc();
        axi.w_ready = 1'b1; #2;
        n_chk++; if ({axi.aw_valid, axi.w_valid, data_gnt} !== 3'b011) begin n_fail++; $display("FAIL wr_c3_gnt: got %b want 011", {axi.aw_valid, axi.w_valid, data_gnt}); end
        cyc();
        data_req = 1'b0; axi.w_ready = 1'b0; #2;
        n_chk++; if ({axi.b_ready, axi.r_ready, axi.w_valid} !== 3'b100) begin n_fail++; $display("FAIL wr_bready: got %b want 100", {axi.b_ready, axi.r_ready, axi.w_valid}); end
        cyc();
        axi.b_valid = 1'b1; axi.b_resp = RESP_SLVERR; #2;
        n_chk++; if ({data_rvalid, data_err} !== 2'b11) begin n_fail++; $display("FAIL wr_slverr: got %b want 11", {data_rvalid, data_err}); end
        n_chk++; if (data_rdata !== 32'h0) begin n_fail++; $display("FAIL wr_rdata_zero: got %h want 0", data_rdata); end
        cyc();
        axi.b_valid = 1'b0; #2;
        n_chk++; if (axi.b_ready !== 1'b0) begin n_fail++; $display("FAIL wr_bready_idle: got %0b want 0", axi.b_ready); end
    endtask

    task automatic test_write_pipelined();
        cyc();
        data_req = 1'b1; data_we = 1'b1; data_addr = 32'h20C; data_be = 4'b1001; data_wdata = 32'h1;
        axi.aw_ready = 1'b1; axi.w_ready = 1'b1; #2;
        n_chk++; if (data_gnt !== 1'b1 || axi.w_strb !== 8'h90) begin n_fail++; $display("FAIL wp_same_cycle: got %0b/%h want 1/90", data_gnt, axi.w_strb); end
        cyc();
        data_addr = 32'h210; data_be = 4'b0110; axi.aw_ready = 1'b0; #2;
        n_chk++; if ({axi.aw_valid, axi.w_valid, data_gnt} !== 3'b110) begin n_fail++; $display("FAIL wp_w_first: got %b want 110", {axi.aw_valid, axi.w_valid, data_gnt}); end
        cyc();
        axi.aw_ready = 1'b1; axi.w_ready = 1'b0; #2;
        n_chk++; if ({axi.aw_valid, axi.w_valid, data_gnt} !== 3'b101) begin n_fail++; $display("FAIL wp_aw_second: got %b want 101", {axi.aw_valid, axi.w_valid, data_gnt}); end
        n_chk++; if (axi.w_strb !== 8'h06) begin n_fail++; $display("FAIL wp_strb: got %h want 06", axi.w_strb); end
        cyc();
        data_req = 1'b0; axi.aw_ready = 1'b0; axi.b_valid = 1'b1; axi.b_resp = RESP_OKAY; #2;
        n_chk++; if ({data_rvalid, data_err} !== 2'b10) begin n_fail++; $display("FAIL wp_okay: got %b want 10", {data_rvalid, data_err}); end
        cyc();
        axi.b_resp = RESP_EXOKAY; #2;
        n_chk++; if ({data_rvalid, data_err} !== 2'b10) begin n_fail++; $display("FAIL wp_exokay: got %b want 10", {data_rvalid, data_err}); end
        cyc();
        axi.b_valid = 1'b0; #2;
        n_chk++; if (axi.b_ready !== 1'b0) begin n_fail++; $display("FAIL wp_drained: got %0b want 0", axi.b_ready); end
    endtask

    task automatic test_type_switch();
        cyc();
        data_req = 1'b1; data_we = 1'b0; data_addr = 32'h0; axi.ar_ready = 1'b1; #2;
        n_chk++; if (data_gnt !== 1'b1) begin n_fail++; $display("FAIL ts_rd_gnt: got %0b want 1", data_gnt); end
        cyc();
        axi.ar_ready = 1'b0; data_we = 1'b1; data_addr = 32'h4; data_be = 4'hF; data_wdata = 32'h0BAD_F00D;
        axi.aw_ready = 1'b1; axi.w_ready = 1'b1; #2;
        n_chk++; if ({axi.aw_valid, axi.w_valid, data_gnt} !== 3'b000) begin n_fail++; $display("FAIL ts_stall: got %b want 000", {axi.aw_valid, axi.w_valid, data_gnt}); end
        cyc();
        axi.r_valid = 1'b1; axi.r_data = 64'h5555_6666_7777_8888; axi.r_resp = RESP_DECERR; #2;
        n_chk++; if ({data_rvalid, data_err, axi.aw_valid} !== 3'b110) begin n_fail++; $display("FAIL ts_pop: got %b want 110", {data_rvalid, data_err, axi.aw_valid}); end
        n_chk++; if (data_rdata !== 32'h7777_8888) begin n_fail++; $display("FAIL ts_rdata: got %h want 77778888", data_rdata); end
        cyc();
        axi.r_valid = 1'b0; #2;
        n_chk++; if ({axi.aw_valid, axi.w_valid, data_gnt} !== 3'b111) begin n_fail++; $display("FAIL ts_wr_issue: got %b want 111", {axi.aw_valid, axi.w_valid, data_gnt}); end
        n_chk++; if (axi.w_strb !== 8'hF0) begin n_fail++; $display("FAIL ts_strb: got %h want f0", axi.w_strb); end
        cyc();
        data_req = 1'b0; axi.aw_ready = 1'b0; axi.w_ready = 1'b0; axi.b_valid = 1'b1; axi.b_resp = RESP_OKAY; #2;
        n_chk++; if ({data_rvalid, data_err} !== 2'b10) begin n_fail++; $display("FAIL ts_bresp: got %b want 10", {data_rvalid, data_err}); end
        cyc();
        axi.b_valid = 1'b0;
    endtask

    task automatic test_wrap();
        data_we = 1'b0; axi.ar_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            data_req = 1'b1; data_addr = 32'(i * 4); #2;
            n_chk++; if (data_gnt !== 1'b1) begin n_fail++; $display("FAIL wrap_gnt%0d: got %0b want 1", i, data_gnt); end
        end
        cyc();
        data_addr = 32'hC; axi.r_valid = 1'b1; axi.r_resp = RESP_OKAY; axi.r_data = {32'hB000_0000, 32'hA000_0000}; #2;
        n_chk++; if ({data_gnt, data_rvalid} !== 2'b11) begin n_fail++; $display("FAIL wrap_simul: got %b want 11", {data_gnt, data_rvalid}); end
        n_chk++; if (data_rdata !== 32'hA000_0000) begin n_fail++; $display("FAIL wrap_rdata0: got %h want a0000000", data_rdata); end
        cyc();
        axi.r_valid = 1'b0; data_addr = 32'h10; #2;
        n_chk++; if (data_gnt !== 1'b1) begin n_fail++; $display("FAIL wrap_cnt3_gnt: got %0b want 1", data_gnt); end
        cyc();
        data_addr = 32'h14; #2;
        n_chk++; if (axi.ar_valid !== 1'b0) begin n_fail++; $display("FAIL wrap_full: got %0b want 0", axi.ar_valid); end
        cyc();
        data_req = 1'b0; axi.ar_ready = 1'b0;
        for (int i = 1; i < 5; i++) begin
            axi.r_valid = 1'b1;
            axi.r_data = {32'(32'hB000_0000 + i), 32'(32'hA000_0000 + i)};
            exp = (i % 2 == 1) ? 32'(32'hB000_0000 + i) : 32'(32'hA000_0000 + i);
            #2;
            n_chk++; if (data_rvalid !== 1'b1 || data_rdata !== exp) begin n_fail++; $display("FAIL wrap_rsp%0d: got %0b/%h want 1/%h", i, data_rvalid, data_rdata, exp); end
            cyc();
        end
        axi.r_valid = 1'b0; #2;
        n_chk++; if (axi.r_ready !== 1'b0) begin n_fail++; $display("FAIL wrap_drained: got %0b want 0", axi.r_ready); end
    endtask

    task automatic test_reset_midflight();
        data_we = 1'b0; axi.ar_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            cyc();
            data_req = 1'b1; data_addr = 32'(i * 4); #2;
            n_chk++; if (data_gnt !== 1'b1) begin n_fail++; $display("FAIL rm_gnt%0d: got %0b want 1", i, data_gnt); end
        end
        cyc();
        data_req = 1'b0; axi.ar_ready = 1'b0; #2;
        n_chk++; if (axi.r_ready !== 1'b1) begin n_fail++; $display("FAIL rm_pending: got %0b want 1", axi.r_ready); end
        #2;
        rst = 1'b1; axi.r_valid = 1'b1; axi.r_data = 64'hCAFE_0000_BEEF_0000; #1;
        n_chk++; if ({axi.r_ready, axi.b_ready, data_rvalid, data_gnt, axi.ar_valid} !== 5'b0) begin n_fail++; $display("FAIL rm_async: got %b want 00000", {axi.r_ready, axi.b_ready, data_rvalid, data_gnt, axi.ar_valid}); end
        cyc();
        rst = 1'b0; #2;
        for (int i = 0; i < 2; i++) begin
            n_chk++; if ({data_rvalid, axi.r_ready} !== 2'b00) begin n_fail++; $display("FAIL rm_late%0d: got %b want 00", i, {data_rvalid, axi.r_ready}); end
            cyc(); #2;
        end
        axi.r_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; data_req = 1'b0; data_we = 1'b0; data_addr = '0; data_be = '0; data_wdata = '0; exp = '0;
        axi.aw_ready = 1'b0; axi.w_ready = 1'b0; axi.ar_ready = 1'b0;
        axi.b_valid = 1'b0; axi.b_resp = '0; axi.b_id = '0; axi.b_user = '0;
        axi.r_valid = 1'b0; axi.r_data = '0; axi.r_resp = '0; axi.r_last = 1'b1; axi.r_id = '0; axi.r_user = '0;
        test_reset();
        test_read_single();
        test_back_to_back();
        test_write_split();
        test_write_pipelined();
        test_type_switch();
        test_wrap();
        test_reset_midflight();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, got no finish want finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/core2axi_pipe.md
Name: core2axi_pipe

Overview:
- Successor to the single-outstanding core-to-AXI bridge.
- Converts the core's req/gnt/rvalid data interface into AXI4 single-beat transactions.
- Supports up to MAX_OUTSTANDING in-order transactions, data widths of 32/64/128 bits, and error reporting back to the core.
- Sits between the core's LSU/instruction port and the SoC AXI interconnect.

Parameters:
- AXI4_ADDRESS_WIDTH, 32, address width.
- AXI4_DATA_WIDTH, 64, AXI read/write data width; only 32, 64 or 128 are legal, anything else gives an elaboration error.
- AXI4_ID_WIDTH, 16, AXI ID width.
- AXI4_USER_WIDTH, 10, AXI user width.
- MAX_OUTSTANDING, 4, maximum issued-but-unanswered transactions; range 1..16.
- AXI_ID_VALUE, 0, constant ID driven on aw_id_o and ar_id_o.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous active-high reset.
- data_req_i  in  1  core request.
- data_gnt_o  out  1  request accepted.
- data_rvalid_o  out  1  response valid.
- data_err_o  out  1  response error; qualified by data_rvalid_o.
- data_addr_i  in  AXI4_ADDRESS_WIDTH  byte address.
- data_we_i  in  1  1 = write.
- data_be_i  in  4  byte enables.
- data_wdata_i  in  32  write data.
- data_rdata_o  out  32  read data.
- aw_*/w_*/b_*/ar_*/r_*: full AXI4 master channel set, with the standard widths and names.
- Constant AXI fields: len=0, size=3'b010, burst=INCR, lock/cache/prot/region/qos/user=0, id=AXI_ID_VALUE, w_last_o=1.

Behaviour:
- Reset values: all valid/ready outputs, data_gnt_o, data_rvalid_o and data_err_o are 0. Outstanding count is 0, and the FIFO and aw_done/w_done flags are cleared.
- Reset mid-operation: in-flight transactions are abandoned. No response is produced after release.
- Mode register: outstanding_we holds the type of in-flight traffic.
- Issue permission (issue_ok) requires all of:
  - data_req_i;
  - count < MAX_OUTSTANDING;
  - count == 0, or data_we_i == outstanding_we.
- A type switch therefore stalls until the pipe drains, which keeps responses in order.
- Read issue: ar_valid_o = issue_ok & ~data_we_i. data_gnt_o is asserted in the same cycle as ar_valid_o & ar_ready_i (combinational, zero added latency).
- Write issue:
  - aw_valid_o = issue_ok & we & ~aw_done; w_valid_o = issue_ok & we & ~w_done.
  - aw_done/w_done are set on their individual handshakes.
  - data_gnt_o is asserted in the cycle the second handshake completes, including when both complete in the same cycle. Both flags clear on that grant.
- Valid stability: issue_ok cannot deassert while a request is held, because count only rises on grant and the core holds req/addr/we until gnt. AXI valid therefore never drops before ready.
- On grant:
  - push the lane offset addr[$clog2(AXI4_DATA_WIDTH/8)-1:2] into the FIFO (zero-width when AXI4_DATA_WIDTH is 32);
  - count++;
  - outstanding_we <= data_we_i.
- Ready outputs: r_ready_o = (count != 0) & ~outstanding_we; b_ready_o = (count != 0) & outstanding_we. The core never back-pressures responses.
- Response:
  - data_rvalid_o = r_valid_i & r_ready_o | b_valid_i & b_ready_o, in the same cycle.
  - data_err_o = resp[1], meaning SLVERR or DECERR; OKAY and EXOKAY are not errors.
  - On a response, pop the FIFO and count--.
- Read data: data_rdata_o = r_data_i lane selected by the FIFO head offset. It is 0 when no read response is present.
- Write data: data_wdata_i is replicated across all lanes. w_strb_o = data_be_i shifted to lane addr offset, all other bits 0.
- Simultaneous grant and response: count is unchanged, and FIFO push and pop both occur.
- Full FIFO: with count == MAX_OUTSTANDING, no AXI valid is raised and no gnt is given. A response in the same cycle does not unblock issue until the next cycle, because issue_ok uses the registered count.
- Unexpected r_valid_i/b_valid_i while the matching ready is low is ignored.

Decomposition:
- core2axi_pkg:
  - resp codes OKAY/EXOKAY/SLVERR/DECERR;
  - txn_type_t {TXN_READ, TXN_WRITE};
  - function lane_offset(addr, width).
- Sub-module core2axi_txn_fifo:
  - parametrised DEPTH and DATA_WIDTH;
  - push/pop, full/empty/count;
  - wrap-around pointers;
  - simultaneous push+pop allowed when full.

Test Plan:
- DW=64, read addr 0x104, ar_ready=1, r_data=0xAAAA_BBBB_1111_2222 two cycles later -> gnt in the ar cycle; rdata=0xAAAABBBB, rvalid=1, err=0.
- DW=64, 4 back-to-back reads to 0x0/0x4/0x8/0xC with r_valid held off -> 4 grants; the 5th req gets no ar_valid; responses then return lane-correct data in order.
- Write 0x208 be=4'b0011, aw_ready=1 in cycle 0, w_ready=1 in cycle 3 -> aw_valid drops after cycle 0; gnt in cycle 3; w_strb=8'h03; b_resp=SLVERR -> rvalid=1, err=1.
- Read outstanding, then write request -> no aw/w valid until the read response pops (count 0); the write then issues.
- Grant and r response in the same cycle with count=MAX-1 -> count stays MAX-1; the FIFO head advances correctly across the pointer wrap.
- Assert rst_i with 2 reads outstanding -> all outputs 0 immediately; a late r_valid after release produces no rvalid.
